// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns v with bit idx replaced by b; used to fold the final channel into the result.
  function automatic logic [NCH-1:0] merge_bit(input logic [NCH-1:0] v,
                                               input logic [CH_W-1:0] idx,
                                               input logic b);
    logic [NCH-1:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Control/data bundle between the scan controller and its driver plus downstream mux.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic           start;
  logic           abort;
  logic           mux_out;
  logic           s1;
  logic           s0;
  logic           busy;
  logic           done;
  logic [NCH-1:0] sample;

  modport master (
    output start, abort, mux_out,
    input  s1, s0, busy, done, sample
  );

  modport slave (
    input  start, abort, mux_out,
    output s1, s0, busy, done, sample
  );

endinterface

// File: rtl/mux_scan_sync.sv
// Two-flop synchronizer for the asynchronous mux output (used only with MUX_SCAN_SYNC_EN).
module mux_scan_sync (
  input  logic clk,
  input  logic din,
  output logic dout
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    sync_p0 <= din;
    sync_p1 <= sync_p0;
  end

  assign dout = sync_p1;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux (a..d), holding each select for DWELL cycles, and reports the captured bits.
// Define MUX_SCAN_SYNC_EN to pass mux_out through a 2-flop synchronizer (requires DWELL >= 3).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);

  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be in 1..15");
  end

  logic mux_bit;

`ifdef MUX_SCAN_SYNC_EN
  // Two cycles of synchronizer delay still land inside the same channel's dwell window.
  if (DWELL < 3) begin : g_bad_sync_dwell
    $error("mux_scan_ctrl: DWELL must be >= 3 when MUX_SCAN_SYNC_EN is defined");
  end

  mux_scan_sync u_sync (
    .clk  (clk),
    .din  (bus.mux_out),
    .dout (mux_bit)
  );
`else
  assign mux_bit = bus.mux_out;
`endif

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]  shadow;
  logic [NCH-1:0]  sample_q;
  logic [CH_W-1:0] sel_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      shadow   <= '0;
      sample_q <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          sel_q  <= '0;
          ch     <= '0;
          cnt    <= '0;
          // abort is deliberately not examined here: start always wins in IDLE
          if (bus.start) begin
            state  <= SCAN;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end

        SCAN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            sel_q  <= '0;
            ch     <= '0;
            cnt    <= '0;
            shadow <= '0;
          end else if (cnt == LAST_CNT) begin
            shadow[ch] <= mux_bit;
            cnt        <= '0;
            if (ch == LAST_CH) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              sel_q    <= '0;
              sample_q <= merge_bit(shadow, ch, mux_bit);
            end else begin
              ch    <= ch + CH_W'(1);
              sel_q <= ch + CH_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          ch     <= '0;
          cnt    <= '0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          sel_q  <= '0;
          ch     <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.s1     = sel_q[1];
  assign bus.s0     = sel_q[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sample = sample_q;

endmodule
